// File: rtl/step_ctrl_pkg.sv
// rtl/step_ctrl_pkg.sv - shared state encoding and default board timing for step_ctrl
package step_ctrl_pkg;

  typedef enum logic {
    ST_STEP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // 20 ms debounce and 0.5 s run period at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_RUN_DIV         = 25000000;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchronizer, debounce counter and press-edge pulse for one key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The new level is accepted once it has differed for DEBOUNCE_CYCLES consecutive edges
  assign accept = (sync_b != key_level) && (cnt == CNT_LAST);

  // Two-stage synchronizer; idle (released) level is 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= key_raw;
      sync_b <= sync_a;
    end
  end

  // Debounce counter: any agreement with the held level restarts the stability window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      key_level   <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= accept && key_level;
      if (sync_b == key_level) begin
        cnt <= '0;
      end else if (accept) begin
        cnt       <= '0;
        key_level <= sync_b;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - key-driven CPU clock-enable generator with single-step and free-run modes
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20,
  parameter int RUN_DIV         = DEFAULT_RUN_DIV,
  parameter int DIV_W           = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_step,
  input  logic        key_mode,
  output logic        cpu_en,
  output logic        run_mode,
  output logic [15:0] step_count
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic             en_next;
  logic             step_press;
  logic             mode_press;
  logic             step_level;
  logic             mode_level;
  logic             unused_levels;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_step_key (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_step),
    .key_level  (step_level),
    .press_pulse(step_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_mode_key (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_mode),
    .key_level  (mode_level),
    .press_pulse(mode_press)
  );

  // Debounced levels are not needed here; only the press events drive the controller
  assign unused_levels = step_level ^ mode_level;

  assign run_mode = (state == ST_RUN);

  // Next state, next enable and divider; a mode press always wins and cancels any pulse
  always_comb begin
    state_next = state;
    en_next    = 1'b0;
    div_next   = '0;
    unique case (state)
      ST_STEP: begin
        if (mode_press) state_next = ST_RUN;
        else            en_next    = step_press;
      end
      ST_RUN: begin
        if (mode_press)            state_next = ST_STEP;
        else if (div == DIV_LAST)  en_next    = 1'b1;
        else                       div_next   = div + DIV_W'(1);
      end
    endcase
  end

  // State, divider, registered enable and the step counter that tracks issued enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_STEP;
      div        <= '0;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      state      <= state_next;
      div        <= div_next;
      cpu_en     <= en_next;
      step_count <= step_count + 16'(en_next);
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// tb/tb_step_ctrl.sv - self-checking bench for step_ctrl against a history-window reference model
module tb_step_ctrl;

  localparam int DB = 4;
  localparam int RD = 5;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        key_step_a = 1'b1, key_mode_a = 1'b1;
  logic        key_step_b = 1'b1, key_mode_b = 1'b1;
  logic        cpu_en_a, run_mode_a, cpu_en_b, run_mode_b;
  logic [15:0] step_count_a, step_count_b;

  int errors = 0;
  int checks = 0;

  step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(4), .RUN_DIV(RD), .DIV_W(4)) dut (
    .clk(clk), .rst(rst_a), .key_step(key_step_a), .key_mode(key_mode_a),
    .cpu_en(cpu_en_a), .run_mode(run_mode_a), .step_count(step_count_a)
  );

  step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(4), .RUN_DIV(1), .DIV_W(2)) dut_fast (
    .clk(clk), .rst(rst_b), .key_step(key_step_b), .key_mode(key_mode_b),
    .cpu_en(cpu_en_b), .run_mode(run_mode_b), .step_count(step_count_b)
  );

  always #5 clk = ~clk;

  // Reference model: raw-sample history per key; a level is accepted when the DB samples that
  // reached the debouncer (taken 2..DB+1 edges ago) all disagree with the current level.
  logic        hs [0:DB+1];
  logic        hm [0:DB+1];
  logic        ls, lm, p_step, p_mode, m_run, m_en;
  logic [15:0] m_cnt;
  int          n, run_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= DB + 1; i++) begin
      hs[i] = 1'b1;
      hm[i] = 1'b1;
    end
    ls = 1'b1; lm = 1'b1; p_step = 1'b0; p_mode = 1'b0;
    m_run = 1'b0; m_en = 1'b0; m_cnt = '0; n = 0; run_start = 0;
  endtask

  task automatic model_edge(input logic ks, input logic km);
    logic diff_s, diff_m, ns, nm;
    n++;
    for (int i = DB + 1; i > 0; i--) begin
      hs[i] = hs[i-1];
      hm[i] = hm[i-1];
    end
    hs[0] = ks;
    hm[0] = km;
    diff_s = 1'b1;
    diff_m = 1'b1;
    for (int i = 2; i <= DB + 1; i++) begin
      if (hs[i] == ls) diff_s = 1'b0;
      if (hm[i] == lm) diff_m = 1'b0;
    end
    ns = 1'b0;
    nm = 1'b0;
    if (diff_s) begin ls = ~ls; ns = ~ls; end
    if (diff_m) begin lm = ~lm; nm = ~lm; end
    if (m_run) begin
      if (p_mode) begin m_run = 1'b0; m_en = 1'b0; end
      else m_en = ((n - run_start) % RD == 0);
    end else begin
      if (p_mode) begin m_run = 1'b1; run_start = n; m_en = 1'b0; end
      else m_en = p_step;
    end
    m_cnt  = m_cnt + 16'(m_en);
    p_step = ns;
    p_mode = nm;
  endtask

  // One clock edge: update the model with the inputs present at the edge, then compare
  task automatic tick();
    @(posedge clk);
    if (rst_a) model_reset();
    else model_edge(key_step_a, key_mode_a);
    #1;
    chk("cpu_en", cpu_en_a, m_en);
    chk("run_mode", run_mode_a, m_run);
    chk("step_count", step_count_a, m_cnt);
  endtask

  task automatic wait_run(input logic target, input int budget, input string tag);
    int k = 0;
    while (run_mode_a !== target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, run_mode_a, target);
  endtask

  initial begin
    int hits, at, k;
    model_reset();
    repeat (3) tick();
    #2 rst_a = 1'b0; rst_b = 1'b0;

    // Idle with both keys released
    repeat (50) tick();
    chk("idle_count", step_count_a, 16'd0);

    // Held step press: one enable after edge DB+3
    key_step_a = 1'b0;
    hits = 0; at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_en_a === 1'b1) begin hits++; at = i; end
    end
    chk("step_hits", hits, 1);
    chk("step_edge", at, DB + 3);
    key_step_a = 1'b1;
    repeat (20) tick();
    chk("step_after_release", step_count_a, 16'd1);

    // Bouncing press never stable for DB cycles
    key_step_a = 1'b0; repeat (3) tick();
    key_step_a = 1'b1; repeat (1) tick();
    key_step_a = 1'b0; repeat (3) tick();
    key_step_a = 1'b1; repeat (20) tick();
    chk("bounce_count", step_count_a, 16'd1);

    // Run mode: pulse every RD cycles, step presses ignored, second mode press stops it
    key_mode_a = 1'b0;
    wait_run(1'b1, 30, "run_enter");
    key_mode_a = 1'b1;
    repeat (20) tick();
    chk("run_count_20", step_count_a, 16'd5);
    key_step_a = 1'b0; repeat (10) tick();
    key_step_a = 1'b1; repeat (10) tick();
    key_mode_a = 1'b0;
    wait_run(1'b0, 30, "run_exit");
    key_mode_a = 1'b1;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cpu_en_a === 1'b1) hits++;
    end
    chk("run_stopped", hits, 0);

    // Simultaneous step and mode press: mode wins, no enable
    key_step_a = 1'b0; key_mode_a = 1'b0;
    wait_run(1'b1, 30, "both_enter");
    chk("both_no_en", cpu_en_a, 1'b0);
    key_step_a = 1'b1; key_mode_a = 1'b1;
    repeat (12) tick();

    // Asynchronous reset between edges while running
    #2 rst_a = 1'b1;
    #1;
    chk("rst_cpu_en", cpu_en_a, 1'b0);
    chk("rst_run_mode", run_mode_a, 1'b0);
    chk("rst_step_count", step_count_a, 16'd0);
    repeat (2) tick();
    #2 rst_a = 1'b0;

    // Random key activity against the model
    for (int seg = 0; seg < 60; seg++) begin
      key_step_a = 1'($urandom_range(0, 1));
      key_mode_a = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      repeat ($urandom_range(1, 9)) tick();
    end
    key_step_a = 1'b1; key_mode_a = 1'b1;
    repeat (10) tick();

    // RUN_DIV=1: continuous enable, counter wraps after 65536 cycles
    key_mode_b = 1'b0;
    k = 0;
    while (run_mode_b !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    chk("fast_enter", run_mode_b, 1'b1);
    key_mode_b = 1'b1;
    chk("fast_count_entry", step_count_b, 16'd0);
    repeat (65535) tick();
    chk("fast_count_ffff", step_count_b, 16'hFFFF);
    chk("fast_en_high", cpu_en_b, 1'b1);
    tick();
    chk("fast_count_wrap", step_count_b, 16'h0000);
    #2 rst_b = 1'b1;
    #1;
    chk("fast_rst_cpu_en", cpu_en_b, 1'b0);
    chk("fast_rst_run_mode", run_mode_b, 1'b0);
    chk("fast_rst_count", step_count_b, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
